// File: rtl/sonar_tof_capture.sv
// rtl/sonar_tof_capture.sv - time-of-flight capture of comparator edges into a bus-readable event FIFO
module sonar_tof_capture #(
    parameter int N_CH  = 10,
    parameter int TS_W  = 12,
    parameter int DEPTH = 8
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wb_valid_i,
    input  logic [3:0]      wbs_adr_i,
    input  logic [15:0]     wbs_dat_i,
    input  logic            wbs_strb_i,
    output logic            wbs_ack_o,
    output logic [15:0]     wbs_dat_o,
    input  logic            ce_pcm,
    input  logic            mclear,
    input  logic [N_CH-1:0] cmp,
    output logic            irq
);

    localparam int            AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE   = 1;
    localparam logic [TS_W-1:0] TS_ONE  = 1;
    localparam logic [TS_W-1:0] TS_MAX  = '1;
    localparam logic [3:0]    CNT_DEPTH = 4'(DEPTH);

    // Registered state and next-state values
    logic                 ack_q, ack_d;
    logic [15:0]          dat_q, dat_d;
    logic                 irq_q, irq_d;
    logic                 mclear_q;
    logic [N_CH-1:0]      cmp_r_q, cmp_p_q;
    logic [TS_W-1:0]      ts_q, ts_d;
    logic                 run_q, run_d;
    logic [N_CH-1:0]      armed_q, armed_d;
    logic [N_CH-1:0]      pend_q, pend_d;
    logic [TS_W-1:0]      hit_ts_q [N_CH];
    logic [N_CH-1:0]      ch_en_q, ch_en_d;
    logic [TS_W-1:0]      timeout_q, timeout_d;
    logic                 irq_en_q, irq_en_d;
    logic                 ovf_q, ovf_d;
    logic                 tout_q, tout_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [3:0]           count_q, count_d;
    logic [15:0]          mem_q [DEPTH];

    // Combinational helpers
    logic                 acc_s, wr_s, rd_s;
    logic                 wr_ctrl_s, wr_chen_s, wr_fstat_s, wr_tmo_s;
    logic                 empty_s, full_s, pop_s, start_s, tick_s, timeout_evt_s;
    logic [TS_W-1:0]      ts_inc_s;
    logic [N_CH-1:0]      rise_s, hit_s;
    logic                 push_valid_s, do_push_s, ovf_set_s;
    logic [3:0]           push_ch_s;
    logic [TS_W-1:0]      push_ts_s;
    logic [N_CH-1:0]      push_onehot_s;
    logic [15:0]          push_word_s;
    logic [15:0]          rdata_s;
    logic                 unused_bits;

    assign acc_s      = wb_valid_i & ~ack_q;
    assign wr_s       = acc_s & wbs_strb_i;
    assign rd_s       = acc_s & ~wbs_strb_i;
    assign wr_ctrl_s  = wr_s & (wbs_adr_i == 4'd0);
    assign wr_chen_s  = wr_s & (wbs_adr_i == 4'd1);
    assign wr_fstat_s = wr_s & (wbs_adr_i == 4'd3);
    assign wr_tmo_s   = wr_s & (wbs_adr_i == 4'd5);

    assign empty_s    = (count_q == 4'd0);
    assign full_s     = (count_q == CNT_DEPTH);
    assign pop_s      = rd_s & (wbs_adr_i == 4'd4) & ~empty_s;

    assign start_s    = (mclear & ~mclear_q) | (wr_ctrl_s & wbs_dat_i[2]);
    assign tick_s     = run_q & ce_pcm;
    assign ts_inc_s   = ts_q + TS_ONE;
    // The measurement ends on the tick that reaches TIMEOUT (or finds ts already there);
    // the saturation guard keeps ts from wrapping when TIMEOUT was lowered below ts.
    assign timeout_evt_s = tick_s & ((ts_q == timeout_q) |
                                     ((ts_q != TS_MAX) & (ts_inc_s == timeout_q)));

    assign rise_s     = cmp_r_q & ~cmp_p_q;
    assign hit_s      = rise_s & armed_q & {N_CH{run_q}};

    // A full FIFO still accepts the push when a pop frees a slot in the same cycle
    assign do_push_s  = push_valid_s & (~full_s | pop_s);
    assign ovf_set_s  = push_valid_s & full_s & ~pop_s;
    assign push_word_s = 16'({push_ch_s, push_ts_s});

    assign unused_bits = &{1'b0, wbs_dat_i};

    assign wbs_ack_o  = ack_q;
    assign wbs_dat_o  = dat_q;
    assign irq        = irq_q;

    // Select the lowest-index pending channel for this cycle's push
    always_comb begin
        push_valid_s  = 1'b0;
        push_ch_s     = 4'd0;
        push_ts_s     = '0;
        push_onehot_s = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                push_valid_s     = 1'b1;
                push_ch_s        = 4'(i);
                push_ts_s        = hit_ts_q[i];
                push_onehot_s    = '0;
                push_onehot_s[i] = 1'b1;
            end
        end
    end

    // Register read multiplexer
    always_comb begin
        rdata_s = 16'h0000;
        case (wbs_adr_i)
            4'd0:    rdata_s = {12'h000, tout_q, 1'b0, irq_en_q, run_q};
            4'd1:    rdata_s = 16'(ch_en_q);
            4'd2:    rdata_s = 16'(ts_q);
            4'd3:    rdata_s = {5'b00000, ovf_q, full_s, empty_s, 4'b0000, count_q};
            4'd4:    rdata_s = empty_s ? 16'hFFFF : mem_q[rd_ptr_q];
            4'd5:    rdata_s = 16'(timeout_q);
            default: rdata_s = 16'h0000;
        endcase
    end

    // Next-state logic for bus, measurement, capture and FIFO bookkeeping
    always_comb begin
        ack_d     = acc_s;
        dat_d     = rd_s ? rdata_s : 16'h0000;
        irq_d     = irq_en_q & (~empty_s | tout_q);

        ch_en_d   = wr_chen_s ? wbs_dat_i[N_CH-1:0] : ch_en_q;
        timeout_d = wr_tmo_s ? wbs_dat_i[TS_W-1:0] : timeout_q;
        irq_en_d  = wr_ctrl_s ? wbs_dat_i[1] : irq_en_q;

        ts_d      = ts_q;
        run_d     = run_q;
        armed_d   = armed_q & ~hit_s;
        tout_d    = tout_q;
        if (wr_ctrl_s && wbs_dat_i[3]) begin
            tout_d = 1'b0;
        end
        if (start_s) begin
            ts_d    = '0;
            run_d   = 1'b1;
            armed_d = ch_en_q;
            tout_d  = 1'b0;
        end else begin
            if (tick_s && (ts_q != timeout_q) && (ts_q != TS_MAX)) begin
                ts_d = ts_inc_s;
            end
            if (timeout_evt_s) begin
                run_d   = 1'b0;
                armed_d = '0;
                tout_d  = 1'b1;
            end
        end

        pend_d    = (pend_q & ~push_onehot_s) | hit_s;

        ovf_d     = ovf_q;
        if (wr_fstat_s && wbs_dat_i[10]) begin
            ovf_d = 1'b0;
        end
        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end

        wr_ptr_d  = do_push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d  = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        count_d   = count_q + {3'b000, do_push_s} - {3'b000, pop_s};
    end

    // State registers with asynchronous reset
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q     <= 1'b0;
            dat_q     <= 16'h0000;
            irq_q     <= 1'b0;
            mclear_q  <= 1'b0;
            cmp_r_q   <= '0;
            cmp_p_q   <= '0;
            ts_q      <= '0;
            run_q     <= 1'b0;
            armed_q   <= '0;
            pend_q    <= '0;
            ch_en_q   <= '1;
            timeout_q <= '1;
            irq_en_q  <= 1'b0;
            ovf_q     <= 1'b0;
            tout_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= 4'd0;
        end else begin
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            irq_q     <= irq_d;
            mclear_q  <= mclear;
            cmp_r_q   <= cmp;
            cmp_p_q   <= cmp_r_q;
            ts_q      <= ts_d;
            run_q     <= run_d;
            armed_q   <= armed_d;
            pend_q    <= pend_d;
            ch_en_q   <= ch_en_d;
            timeout_q <= timeout_d;
            irq_en_q  <= irq_en_d;
            ovf_q     <= ovf_d;
            tout_q    <= tout_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Per-channel hit timestamps latched on an armed rising edge
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < N_CH; i++) begin
                hit_ts_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (hit_s[i]) begin
                    hit_ts_q[i] <= ts_q;
                end
            end
        end
    end

    // Event storage; validity is tracked by the pointers and count
    always_ff @(posedge wb_clk_i) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_word_s;
        end
    end

endmodule

// File: tb/tb_sonar_tof_capture.sv
// tb/tb_sonar_tof_capture.sv - self-checking bench for sonar_tof_capture
module tb_sonar_tof_capture;

    localparam int N_CH  = 10;
    localparam int TS_W  = 12;
    localparam int DEPTH = 8;
    localparam int TS_MAX = (1 << TS_W) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            valid = 1'b0;
    logic [3:0]      adr = 4'd0;
    logic [15:0]     wdat = 16'h0000;
    logic            strb = 1'b0;
    logic            ack;
    logic [15:0]     rdat;
    logic            ce = 1'b0;
    logic            mclr = 1'b0;
    logic [N_CH-1:0] cmp = '0;
    logic            irq;

    always #5 clk = ~clk;

    sonar_tof_capture #(.N_CH(N_CH), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wb_valid_i (valid),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (wdat),
        .wbs_strb_i (strb),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (rdat),
        .ce_pcm     (ce),
        .mclear     (mclr),
        .cmp        (cmp),
        .irq        (irq)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit              m_run;
    int              m_ts;
    bit [N_CH-1:0]   m_armed;
    bit [N_CH-1:0]   m_chen;
    int              m_to;
    bit              m_tout, m_ovf, m_irqen;
    logic [15:0]     m_q[$];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_run = 0; m_ts = 0; m_armed = '0; m_chen = '1; m_to = TS_MAX;
        m_tout = 0; m_ovf = 0; m_irqen = 0; m_q.delete();
    endtask

    task automatic m_start();
        m_ts = 0; m_run = 1; m_armed = m_chen; m_tout = 0;
    endtask

    task automatic m_stop();
        m_run = 0; m_armed = '0; m_tout = 1;
    endtask

    task automatic m_tick();
        if (m_run) begin
            if (m_ts == m_to) m_stop();
            else if (m_ts < TS_MAX) begin
                m_ts++;
                if (m_ts == m_to) m_stop();
            end
        end
    endtask

    task automatic m_rise(input logic [N_CH-1:0] mask);
        for (int c = 0; c < N_CH; c++) begin
            if (mask[c] && m_run && m_armed[c]) begin
                m_armed[c] = 1'b0;
                if (m_q.size() < DEPTH) m_q.push_back(16'((c << TS_W) | m_ts));
                else m_ovf = 1;
            end
        end
    endtask

    function automatic logic [15:0] m_exp(input logic [3:0] a);
        bit e, f;
        e = (m_q.size() == 0);
        f = (m_q.size() == DEPTH);
        case (a)
            4'd0: return {12'h000, m_tout, 1'b0, m_irqen, m_run};
            4'd1: return 16'(m_chen);
            4'd2: return 16'(m_ts);
            4'd3: return {5'b00000, m_ovf, f, e, 4'b0000, 4'(m_q.size())};
            4'd4: return e ? 16'hFFFF : m_q[0];
            4'd5: return 16'(m_to);
            default: return 16'h0000;
        endcase
    endfunction

    task automatic bus_rd(input logic [3:0] a, output logic [15:0] d);
        @(negedge clk); valid = 1'b1; adr = a; strb = 1'b0;
        @(posedge clk); #1; valid = 1'b0;
        chk("rd_ack_high", 16'(ack), 16'h0001);
        d = rdat;
        @(posedge clk); #1;
        chk("rd_ack_one_cycle", 16'(ack), 16'h0000);
        chk("rd_dat_idle_zero", rdat, 16'h0000);
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk); valid = 1'b1; adr = a; strb = 1'b1; wdat = d;
        @(posedge clk); #1; valid = 1'b0; strb = 1'b0;
        chk("wr_ack_high", 16'(ack), 16'h0001);
        chk("wr_dat_zero", rdat, 16'h0000);
        @(posedge clk); #1;
        case (a)
            4'd0: begin
                m_irqen = d[1];
                if (d[3]) m_tout = 0;
                if (d[2]) m_start();
            end
            4'd1: m_chen = d[N_CH-1:0];
            4'd3: if (d[10]) m_ovf = 0;
            4'd5: m_to = int'(d[TS_W-1:0]);
            default: ;
        endcase
    endtask

    task automatic rd_lit(input logic [3:0] a, input logic [15:0] exp, input string tag);
        logic [15:0] d;
        bus_rd(a, d);
        chk(tag, d, exp);
        if (a == 4'd4 && m_q.size() > 0) void'(m_q.pop_front());
    endtask

    task automatic rd_mod(input logic [3:0] a, input string tag);
        logic [15:0] d, e;
        e = m_exp(a);
        bus_rd(a, d);
        chk(tag, d, e);
        if (a == 4'd4 && m_q.size() > 0) void'(m_q.pop_front());
    endtask

    task automatic do_tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); ce = 1'b1;
            @(negedge clk); ce = 1'b0;
            m_tick();
        end
    endtask

    task automatic do_mclear_start();
        @(negedge clk); mclr = 1'b1;
        @(negedge clk);
        @(negedge clk); mclr = 1'b0;
        @(negedge clk);
        m_start();
    endtask

    task automatic do_rise(input logic [N_CH-1:0] mask);
        @(negedge clk); cmp = mask;
        repeat (N_CH + 4) @(negedge clk);
        cmp = '0;
        repeat (3) @(negedge clk);
        m_rise(mask);
    endtask

    // Rising edge timed so its FIFO push lands on the same cycle as an FDATA pop
    task automatic rise_with_pop(input int ch, output logic [15:0] d);
        logic [N_CH-1:0] mask;
        mask = '0;
        mask[ch] = 1'b1;
        @(negedge clk); cmp = mask;
        @(negedge clk);
        @(negedge clk); valid = 1'b1; adr = 4'd4; strb = 1'b0;
        @(posedge clk); #1; valid = 1'b0;
        chk("pop_push_ack", 16'(ack), 16'h0001);
        d = rdat;
        repeat (4) @(negedge clk);
        cmp = '0;
        repeat (3) @(negedge clk);
        if (m_q.size() > 0) void'(m_q.pop_front());
        m_rise(mask);
    endtask

    task automatic chk_irq(input string tag);
        @(negedge clk); @(negedge clk);
        chk(tag, 16'(irq), 16'(m_irqen & ((m_q.size() != 0) | m_tout)));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] d;
        logic [N_CH-1:0] msk;
        int op;

        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_ack", 16'(ack), 16'h0000);
        chk("rst_dat", rdat, 16'h0000);
        chk("rst_irq", 16'(irq), 16'h0000);
        rst = 1'b0;

        rd_lit(4'd0, 16'h0000, "rst_ctrl");
        rd_lit(4'd1, 16'h03FF, "rst_chen");
        rd_lit(4'd2, 16'h0000, "rst_tsnow");
        rd_lit(4'd3, 16'h0100, "rst_fstat");
        rd_lit(4'd4, 16'hFFFF, "rst_fdata_empty");
        rd_lit(4'd5, 16'h0FFF, "rst_timeout");
        chk("rst_irq_after", 16'(irq), 16'h0000);

        // Single-channel capture after an mclear start
        do_mclear_start();
        rd_lit(4'd0, 16'h0001, "run_after_mclear");
        do_tick(37);
        rd_lit(4'd2, 16'h0025, "tsnow_37");
        do_rise(10'b00_0000_1000);
        rd_lit(4'd3, 16'h0001, "fstat_one_event");
        rd_lit(4'd4, 16'h3025, "fdata_ch3");
        rd_lit(4'd3, 16'h0100, "fstat_empty_after_pop");
        do_rise(10'b00_0000_1000);
        rd_lit(4'd3, 16'h0100, "second_edge_ignored");

        // Simultaneous edges drain in ascending order with equal timestamps
        bus_wr(4'd0, 16'h0004);
        do_tick(5);
        do_rise(10'b00_1000_0100);
        rd_lit(4'd3, 16'h0002, "fstat_two_events");
        rd_lit(4'd4, 16'h2005, "fdata_ch2");
        rd_lit(4'd4, 16'h7005, "fdata_ch7");

        // Timeout and interrupt
        bus_wr(4'd5, 16'h000A);
        do_mclear_start();
        do_tick(10);
        rd_lit(4'd0, 16'h0008, "ctrl_timeout");
        rd_lit(4'd2, 16'h000A, "ts_held_at_timeout");
        do_tick(3);
        rd_lit(4'd2, 16'h000A, "ts_no_count_after_timeout");
        bus_wr(4'd0, 16'h0002);
        chk_irq("irq_on_timeout");
        chk("irq_high_literal", 16'(irq), 16'h0001);
        bus_wr(4'd0, 16'h0008);
        chk_irq("irq_cleared");
        chk("irq_low_literal", 16'(irq), 16'h0000);
        rd_lit(4'd0, 16'h0000, "ctrl_cleared");

        // Fill, overflow, simultaneous push and pop on a full FIFO
        bus_wr(4'd5, 16'h0FFF);
        do_mclear_start();
        do_tick(3);
        do_rise(10'b00_1111_1111);
        do_tick(2);
        do_rise(10'b11_0000_0000);
        rd_lit(4'd3, 16'h0608, "fstat_full_overflow");
        do_mclear_start();
        do_tick(1);
        rise_with_pop(5, d);
        chk("pop_during_push_head", d, 16'h0003);
        rd_lit(4'd3, 16'h0608, "fstat_count_kept");
        for (int i = 1; i < 8; i++) rd_lit(4'd4, 16'((i << 12) | 3), "fill_order");
        rd_lit(4'd4, 16'h5001, "fill_last_pushed");
        rd_lit(4'd4, 16'hFFFF, "fill_drained");
        bus_wr(4'd3, 16'h0400);
        rd_lit(4'd3, 16'h0100, "overflow_cleared");

        // Randomized operations against the reference model
        for (int it = 0; it < 60; it++) begin
            op = int'($urandom_range(0, 7));
            case (op)
                0: do_mclear_start();
                1: bus_wr(4'd0, 16'(4 | (m_irqen ? 2 : 0)));
                2: do_tick(int'($urandom_range(1, 20)));
                3: begin
                    msk = N_CH'($urandom_range(1, (1 << N_CH) - 1));
                    do_rise(msk);
                end
                4: rd_mod(4'd4, "rnd_fdata");
                5: rd_mod(4'd3, "rnd_fstat");
                6: begin
                    case ($urandom_range(0, 3))
                        0: bus_wr(4'd5, ($urandom_range(0, 1) != 0) ? 16'h0FFF : 16'($urandom_range(0, 40)));
                        1: bus_wr(4'd1, 16'($urandom_range(0, (1 << N_CH) - 1)));
                        2: bus_wr(4'd3, 16'h0400);
                        default: bus_wr(4'd0, 16'($urandom_range(0, 15)));
                    endcase
                end
                default: rd_mod(4'($urandom_range(0, 15)), "rnd_reg");
            endcase
            chk_irq("rnd_irq");
        end
        while (m_q.size() > 0) rd_mod(4'd4, "rnd_drain");
        rd_mod(4'd3, "rnd_final_fstat");

        // Asynchronous reset with events queued
        bus_wr(4'd5, 16'h0FFF);
        bus_wr(4'd1, 16'h03FF);
        bus_wr(4'd0, 16'h0002);
        do_mclear_start();
        do_tick(4);
        do_rise(10'b00_0000_0111);
        chk_irq("irq_before_reset");
        chk("irq_before_reset_literal", 16'(irq), 16'h0001);
        @(negedge clk); valid = 1'b1; adr = 4'd2; strb = 1'b0;
        @(posedge clk); #1; valid = 1'b0;
        chk("ack_before_reset", 16'(ack), 16'h0001);
        chk("ts_before_reset", rdat, 16'h0004);
        #1; rst = 1'b1;
        #1;
        chk("async_rst_ack", 16'(ack), 16'h0000);
        chk("async_rst_dat", rdat, 16'h0000);
        chk("async_rst_irq", 16'(irq), 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_reset();
        rd_lit(4'd3, 16'h0100, "fstat_after_reset");
        rd_lit(4'd0, 16'h0000, "ctrl_after_reset");
        rd_lit(4'd4, 16'hFFFF, "fdata_after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
